dvi_timing_ctrl: RTL and testbench
==================================

Name: dvi_timing_ctrl

Overview:
- Video timing scheduler that sequences the DVI/TMDS encoder inputs (dvi_de, RGB, hsync, vsync, ctl).
- Generates horizontal and vertical timing counters and pulls pixels from an upstream stream buffer through a valid/ready handshake.
- Aligns the buffer's frame start to the raster origin, then drives registered encoder inputs.
- Sits between the receive-side pixel FIFO and the RGB-to-TMDS serializer path.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level

Ports:
- vga_clk_sig  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run timing; 0 forces IDLE
- pix_data  in  24  {R[23:16],G[15:8],B[7:0]} head of stream
- pix_valid  in  1  head pixel present
- pix_sof  in  1  head pixel is first pixel of a frame
- pix_ready  out  1  head consumed this cycle when pix_valid=1 (combinational from state/counters/head)
- clear_flags  in  1  clears sticky flags
- dvi_de  out  1  data enable to encoder
- dvi_red, dvi_grn, dvi_blu  out  8 each  pixel to encoder
- dvi_hsync, dvi_vsync  out  1 each  sync to encoder
- dvi_ctl  out  4  constant 4'b0000 (DVI mode)
- frame_start  out  1  one-cycle pulse on first active pixel output
- underflow  out  1  sticky: active pixel requested while pix_valid=0
- misalign  out  1  sticky: sof position mismatch

Behaviour:
- Clock is vga_clk_sig; reset is synchronous and active-high. No other clock or reset.
- H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and wraps at V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync is line-based; it changes only with v_cnt.
- All dvi_* outputs and frame_start are registered: they reflect the counter position of the previous cycle (latency 1).

Reset / IDLE values:
- dvi_de=0, colours 0, dvi_hsync=~HS_POL, dvi_vsync=~VS_POL, dvi_ctl=0.
- frame_start=0, underflow=0, misalign=0, h_cnt=v_cnt=0.

States:
- IDLE
  - Counters held at 0, outputs at idle values, pix_ready=0.
  - enable=1 -> ALIGN next cycle.
- ALIGN
  - Counters run and syncs are generated; dvi_de=0, colours 0.
  - pix_ready = pix_valid & ~pix_sof: flushes non-sof pixels at any raster position.
  - At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 with pix_valid & pix_sof -> RUN. The sof pixel is not consumed in that cycle.
- RUN
  - Counters run. In the active region pix_ready=1 except on a misalign (below); outside active pix_ready=0.
  - Active pixel with pix_valid=1: output pix_data with dvi_de=1.
  - Active pixel with pix_valid=0: output black with dvi_de=1; set underflow; stay in RUN.
  - Misalign case 1: at (0,0) the head is valid with pix_sof=0.
  - Misalign case 2: at an active position other than (0,0) the head has pix_sof=1.
  - On either misalign: pix_ready=0, output black with dvi_de=1, set misalign, -> ALIGN.
  - Underflow at (0,0): counts as underflow only, not misalign.
- frame_start=1 for exactly the output cycle of pixel (0,0) in RUN.
- enable=0 in any state: IDLE next cycle, with outputs and counters at idle values. Sticky flags are retained.
- Reset mid-frame: same as enable=0, and flags are cleared.
- clear_flags clears underflow/misalign. If a set event occurs in the same cycle, set wins.

Test Plan:
Small parameters for all tests: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6). HS_POL=VS_POL=1.

1. Reset held, enable=1 -> all outputs at idle values, pix_ready=0. Release -> ALIGN. dvi_hsync=1 on output cycles of h_cnt=5,6 of every line. dvi_vsync=1 for the whole of line 4. dvi_de=0.
2. Stream of 3 non-sof pixels then a sof frame, always valid, sink present -> the 3 pixels are flushed in ALIGN. RUN begins at the boundary. The first dvi_de=1 cycle outputs the sof pixel with frame_start=1. Exactly 12 pixels are consumed per frame, 4 per line on lines 0-2. underflow=misalign=0.
3. In RUN, pix_valid=0 for pixel (2,1) -> that output is {0,0,0} with dvi_de=1. underflow=1 and stays set. The next pixel is consumed normally. clear_flags then clears it.
4. sof head presented at pixel (1,1) -> pix_ready=0 that cycle, black output, misalign=1, state ALIGN. RUN resumes at the next frame boundary with that sof pixel.
5. Deassert enable mid-line in RUN -> next output cycle: dvi_de=0, syncs inactive, h_cnt=v_cnt=0, pix_ready=0. Re-enable -> realigns via ALIGN.
6. clear_flags asserted in the same cycle as an underflow event -> underflow reads 1 afterwards.

Source files
------------

// File: rtl/dvi_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dvi_timing_ctrl
//   Raster timing scheduler in front of the RGB-to-TMDS encoder. It runs the
//   horizontal/vertical counters and pulls pixels from the upstream pixel FIFO
//   with a valid/ready handshake. Before pixels are shown, the FIFO's
//   start-of-frame pixel is locked onto raster position (0,0). All encoder
//   inputs are registered, so they show the counter position of the previous
//   cycle.
//
// Ports
//   vga_clk_sig  in   pixel clock (rising edge)
//   reset        in   synchronous, active-high
//   enable       in   0 sends the block to IDLE
//   pix_data     in   [23:0] {R,G,B} head of stream
//   pix_valid    in   head pixel present
//   pix_sof      in   head pixel is the first pixel of a frame
//   pix_ready    out  head consumed this cycle (combinational)
//   clear_flags  in   clears the sticky flags (a same-cycle set wins)
//   dvi_de       out  data enable
//   dvi_red/grn/blu out [7:0] pixel colour
//   dvi_hsync/vsync out syncs, polarity set by HS_POL/VS_POL
//   dvi_ctl      out  [3:0] always 0 (DVI mode)
//   frame_start  out  pulse on the output cycle of pixel (0,0)
//   underflow    out  sticky: active pixel needed while pix_valid=0
//   misalign     out  sticky: start-of-frame position mismatch
// ---------------------------------------------------------------------------
module dvi_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        vga_clk_sig,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  input  logic        clear_flags,
  output logic        dvi_de,
  output logic [7:0]  dvi_red,
  output logic [7:0]  dvi_grn,
  output logic [7:0]  dvi_blu,
  output logic        dvi_hsync,
  output logic        dvi_vsync,
  output logic [3:0]  dvi_ctl,
  output logic        frame_start,
  output logic        underflow,
  output logic        misalign
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare value of headroom so every boundary constant (up to the total)
  // fits in the counter width without truncation.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;
  logic            de_reg, de_next;
  logic [23:0]     rgb_reg, rgb_next;
  logic            hsync_reg, hsync_next;
  logic            vsync_reg, vsync_next;
  logic            fs_reg, fs_next;
  logic            underflow_reg, underflow_next;
  logic            misalign_reg, misalign_next;

  // Raster position decode
  logic            h_wrap, at_origin, at_frame_end, in_active, hs_on, vs_on;
  logic [HW-1:0]   h_adv;
  logic [VW-1:0]   v_adv;
  logic            sof_err, uf_set, mis_set;

  assign h_wrap       = (h_cnt_reg == H_LAST);
  assign at_origin    = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign at_frame_end = h_wrap && (v_cnt_reg == V_LAST);
  assign in_active    = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
  assign hs_on        = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign vs_on        = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
  assign h_adv        = h_wrap ? '0 : h_cnt_reg + 1'b1;
  assign v_adv        = h_wrap ? ((v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1)
                               : v_cnt_reg;

  // A valid head whose sof flag disagrees with the raster position: a missing
  // sof at the origin, or a stray sof anywhere else in the active area.
  assign sof_err = pix_valid && (at_origin ? ~pix_sof : pix_sof);

  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    de_next    = 1'b0;
    rgb_next   = '0;
    hsync_next = ~HS_POL;
    vsync_next = ~VS_POL;
    fs_next    = 1'b0;
    pix_ready  = 1'b0;
    uf_set     = 1'b0;
    mis_set    = 1'b0;

    if (reset || !enable) begin
      // Nothing is consumed here: the pixel could not be shown anyway.
      state_next = ST_IDLE;
      h_cnt_next = '0;
      v_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ALIGN;
        end
        ST_ALIGN: begin
          h_cnt_next = h_adv;
          v_cnt_next = v_adv;
          hsync_next = hs_on ? HS_POL : ~HS_POL;
          vsync_next = vs_on ? VS_POL : ~VS_POL;
          // Discard anything ahead of the next sof; the sof itself is held
          // until the raster reaches the origin.
          pix_ready  = pix_valid & ~pix_sof;
          if (at_frame_end && pix_valid && pix_sof) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          h_cnt_next = h_adv;
          v_cnt_next = v_adv;
          hsync_next = hs_on ? HS_POL : ~HS_POL;
          vsync_next = vs_on ? VS_POL : ~VS_POL;
          if (in_active) begin
            de_next = 1'b1;
            fs_next = at_origin;
            if (sof_err) begin
              mis_set    = 1'b1;
              state_next = ST_ALIGN;
            end else begin
              pix_ready = 1'b1;
              if (pix_valid) begin
                rgb_next = pix_data;
              end else begin
                uf_set = 1'b1;
              end
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    underflow_next = uf_set  | (underflow_reg & ~clear_flags);
    misalign_next  = mis_set | (misalign_reg  & ~clear_flags);
  end

  always_ff @(posedge vga_clk_sig) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      de_reg        <= 1'b0;
      rgb_reg       <= '0;
      hsync_reg     <= ~HS_POL;
      vsync_reg     <= ~VS_POL;
      fs_reg        <= 1'b0;
      underflow_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      h_cnt_reg     <= h_cnt_next;
      v_cnt_reg     <= v_cnt_next;
      de_reg        <= de_next;
      rgb_reg       <= rgb_next;
      hsync_reg     <= hsync_next;
      vsync_reg     <= vsync_next;
      fs_reg        <= fs_next;
      underflow_reg <= underflow_next;
      misalign_reg  <= misalign_next;
    end
  end

  // Split the packed colour register into its three 8-bit channels (B,G,R).
  logic [7:0] rgb_chan [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign rgb_chan[gi] = rgb_reg[gi*8 +: 8];
  end

  assign dvi_blu     = rgb_chan[0];
  assign dvi_grn     = rgb_chan[1];
  assign dvi_red     = rgb_chan[2];
  assign dvi_de      = de_reg;
  assign dvi_hsync   = hsync_reg;
  assign dvi_vsync   = vsync_reg;
  assign dvi_ctl     = 4'b0000;
  assign frame_start = fs_reg;
  assign underflow   = underflow_reg;
  assign misalign    = misalign_reg;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dvi_timing_ctrl
//   Randomized bench for dvi_timing_ctrl on a tiny 8x6 raster. An upstream
//   source queue supplies frames (sometimes preceded by junk pixels) with
//   random valid dropouts; enable, reset and clear_flags are toggled at random.
//   A reference model tracks the raster as a linear pixel index inside the
//   frame and predicts pix_ready plus every registered output each cycle.
// ---------------------------------------------------------------------------
module tb_dvi_timing_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int N_CYC = 4000;

  localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        reset, enable, pix_valid, pix_sof, clear_flags;
  logic [23:0] pix_data;
  logic        pix_ready, dvi_de, dvi_hsync, dvi_vsync;
  logic [7:0]  dvi_red, dvi_grn, dvi_blu;
  logic [3:0]  dvi_ctl;
  logic        frame_start, underflow, misalign;

  always #5 clk = ~clk;

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .vga_clk_sig(clk),
    .reset(reset),
    .enable(enable),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .clear_flags(clear_flags),
    .dvi_de(dvi_de),
    .dvi_red(dvi_red),
    .dvi_grn(dvi_grn),
    .dvi_blu(dvi_blu),
    .dvi_hsync(dvi_hsync),
    .dvi_vsync(dvi_vsync),
    .dvi_ctl(dvi_ctl),
    .frame_start(frame_start),
    .underflow(underflow),
    .misalign(misalign)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_frames = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Upstream stream buffer
  typedef struct {
    logic [23:0] d;
    bit          sof;
  } pix_t;
  pix_t src_q[$];

  task automatic refill();
    pix_t p;
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        p.d = 24'($urandom); p.sof = 1'b0;
        src_q.push_back(p);
      end
    end
    for (int i = 0; i < HA * VA; i++) begin
      p.d = 24'($urandom); p.sof = (i == 0);
      src_q.push_back(p);
    end
  endtask

  // Reference model state and predictions
  int          m_mode = M_IDLE;
  int          m_pos  = 0;
  logic        e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;
  logic        e_uf = 1'b0, e_mis = 1'b0, e_ready = 1'b0;
  logic [23:0] e_rgb = '0;

  task automatic model_step();
    int h, v;
    bit act, sof_bad, uf_ev, mis_ev;
    h = m_pos % HT;
    v = m_pos / HT;
    act     = (h < HA) && (v < VA);
    sof_bad = pix_valid && ((m_pos == 0) ? !pix_sof : pix_sof);
    uf_ev = 0; mis_ev = 0;
    e_ready = 1'b0;
    e_de = 1'b0; e_rgb = '0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_pos = 0;
      e_uf = 1'b0; e_mis = 1'b0;
    end else begin
      if (!enable) begin
        m_mode = M_IDLE; m_pos = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_ALIGN;
      end else begin
        e_hs = (h >= HA + HF) && (h < HA + HF + HS);
        e_vs = (v >= VA + VF) && (v < VA + VF + VS);
        if (m_mode == M_ALIGN) begin
          e_ready = pix_valid && !pix_sof;
          if (m_pos == FT - 1 && pix_valid && pix_sof) m_mode = M_RUN;
        end else if (act) begin
          e_de = 1'b1;
          e_fs = (m_pos == 0);
          if (sof_bad) begin
            mis_ev = 1; m_mode = M_ALIGN;
          end else begin
            e_ready = 1'b1;
            if (pix_valid) e_rgb = pix_data;
            else uf_ev = 1;
          end
        end
        m_pos = (m_pos + 1) % FT;
      end
      e_uf  = uf_ev  || (e_uf  && !clear_flags);
      e_mis = mis_ev || (e_mis && !clear_flags);
    end
  endtask

  initial begin
    int rst_left, dis_left;
    reset = 1'b1; enable = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_data = '0; clear_flags = 1'b0;
    rst_left = 3; dis_left = 0;
    repeat (2) @(posedge clk);

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      check_eq("dvi_de", 32'(dvi_de), 32'(e_de));
      check_eq("rgb", 32'({dvi_red, dvi_grn, dvi_blu}), 32'(e_rgb));
      check_eq("hsync", 32'(dvi_hsync), 32'(e_hs));
      check_eq("vsync", 32'(dvi_vsync), 32'(e_vs));
      check_eq("dvi_ctl", 32'(dvi_ctl), 32'd0);
      check_eq("frame_start", 32'(frame_start), 32'(e_fs));
      check_eq("underflow", 32'(underflow), 32'(e_uf));
      check_eq("misalign", 32'(misalign), 32'(e_mis));
      if (frame_start) begin
        n_frames++;
        $display("cycle %0d: frame %0d first pixel %06h uf=%0b mis=%0b",
                 cyc, n_frames, {dvi_red, dvi_grn, dvi_blu}, underflow, misalign);
      end

      // New inputs for this cycle
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 799) == 0) rst_left = 2;
      enable = (dis_left == 0);
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 299) == 0) dis_left = $urandom_range(1, 5);
      clear_flags = ($urandom_range(0, 7) == 0);
      if (src_q.size() < 16) refill();
      pix_valid = (src_q.size() > 0) && ($urandom_range(0, 19) != 0);
      if (pix_valid) begin
        pix_data = src_q[0].d;
        pix_sof  = src_q[0].sof;
      end else begin
        pix_data = 24'($urandom);
        pix_sof  = 1'($urandom_range(0, 1));
      end

      #1;
      model_step();
      check_eq("pix_ready", 32'(pix_ready), 32'(e_ready));
      if (pix_valid && e_ready) void'(src_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
